// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour reducer: mode encodings, Bayer matrix
// and the per-mode add value used ahead of the saturating shift.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_TRUNC   = 2'b00,
      MODE_ROUND   = 2'b01,
      MODE_DITHER  = 2'b10,
      MODE_TDITHER = 2'b11
   } mode_e;

   localparam logic [3:0] BAYER [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6},
      '{4'd3,  4'd11, 4'd1,  4'd9},
      '{4'd15, 4'd7,  4'd13, 4'd5}
   };

   // Value added before dropping sh LSBs; dither thresholds are rescaled to sh bits.
   function automatic int unsigned add_value(input logic [3:0] t, input int unsigned sh,
                                             input mode_e m);
      int unsigned tv;
      int unsigned res;
      tv  = 32'(t);
      res = 32'd0;
      case (m)
         MODE_TRUNC: res = 32'd0;
         MODE_ROUND: res = (sh == 32'd0) ? 32'd0 : (32'd1 << (sh - 32'd1));
         default:    res = (sh >= 32'd4) ? (tv << (sh - 32'd4)) : (tv >> (32'd4 - sh));
      endcase
      return res;
   endfunction

endpackage

// File: rtl/vga_chan_reduce.sv
// One colour channel: registers input and add value, then registers the
// saturated, shifted result with blanking applied.
module vga_chan_reduce
   import vga_pkg::*;
#(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 4
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic             de_s1,
   input  logic [IN_W-1:0]  add,
   input  logic [IN_W-1:0]  pix_in,
   output logic [OUT_W-1:0] pix_out
);

   localparam int unsigned SH = IN_W - OUT_W;

   logic [IN_W-1:0]  pix_q, pix_d;
   logic [IN_W-1:0]  add_q, add_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [IN_W:0]    sum;
   logic [IN_W-1:0]  sat;

   always_comb begin
      pix_d = pix_in;
      add_d = add;
      sum   = {1'b0, pix_q} + {1'b0, add_q};
      // Carry out means overflow: clamp instead of wrapping to black.
      sat   = sum[IN_W] ? '1 : sum[IN_W-1:0];
      out_d = de_s1 ? OUT_W'(sat >> SH) : '0;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         pix_q <= '0;
         add_q <= '0;
         out_q <= '0;
      end else begin
         pix_q <= pix_d;
         add_q <= add_d;
         out_q <= out_d;
      end
   end

   assign pix_out = out_q;

endmodule

// File: rtl/vga_color_reducer.sv
// Pixel output stage: reduces IN_W-bit RGB to OUT_W bits per channel with a
// per-frame mode, keeping sync and de aligned through the 2-cycle pipeline.
module vga_color_reducer
   import vga_pkg::*;
#(
   parameter int unsigned IN_W         = 8,
   parameter int unsigned OUT_W        = 4,
   parameter int unsigned SYNC_ACT_LOW = 1
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             de,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic [IN_W-1:0]  red_in,
   input  logic [IN_W-1:0]  green_in,
   input  logic [IN_W-1:0]  blue_in,
   output logic [OUT_W-1:0] red,
   output logic [OUT_W-1:0] green,
   output logic [OUT_W-1:0] blue,
   output logic             hsync,
   output logic             vsync,
   output logic             de_out
);

   localparam int unsigned SH        = IN_W - OUT_W;
   localparam logic        SYNC_IDLE = (SYNC_ACT_LOW != 0);

   logic [1:0]      xph_q, xph_d;
   logic [1:0]      yph_q, yph_d;
   logic [1:0]      frm_q, frm_d;
   mode_e           mode_q, mode_d;
   logic            de_s1_q, de_s1_d;
   logic            hs_s1_q, hs_s1_d;
   logic            vs_s1_q, vs_s1_d;
   logic            de_out_q, de_out_d;
   logic            hsync_q, hsync_d;
   logic            vsync_q, vsync_d;
   logic            vs_edge;
   logic            de_fall;
   logic [1:0]      xi, yi;
   logic [3:0]      t;
   logic [IN_W-1:0] add;

   always_comb begin
      // Stage-1 sync/de registers double as the edge-detect history.
      vs_edge  = (vsync_in != SYNC_IDLE) && (vs_s1_q == SYNC_IDLE);
      de_fall  = de_s1_q && !de;

      xph_d    = de ? xph_q + 2'd1 : 2'd0;
      yph_d    = yph_q;
      if (de_fall) yph_d = yph_q + 2'd1;
      if (vs_edge) yph_d = 2'd0;
      frm_d    = vs_edge ? frm_q + 2'd1 : frm_q;
      mode_d   = vs_edge ? mode_e'(mode) : mode_q;

      de_s1_d  = de;
      hs_s1_d  = hsync_in;
      vs_s1_d  = vsync_in;
      de_out_d = de_s1_q;
      hsync_d  = hs_s1_q;
      vsync_d  = vs_s1_q;

      xi  = (mode_q == MODE_TDITHER) ? xph_q + frm_q : xph_q;
      yi  = (mode_q == MODE_TDITHER) ? yph_q + frm_q : yph_q;
      t   = BAYER[yi][xi];
      add = IN_W'(add_value(t, SH, mode_q));
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         xph_q    <= '0;
         yph_q    <= '0;
         frm_q    <= '0;
         mode_q   <= mode_e'(mode);
         de_s1_q  <= 1'b0;
         hs_s1_q  <= SYNC_IDLE;
         vs_s1_q  <= SYNC_IDLE;
         de_out_q <= 1'b0;
         hsync_q  <= SYNC_IDLE;
         vsync_q  <= SYNC_IDLE;
      end else begin
         xph_q    <= xph_d;
         yph_q    <= yph_d;
         frm_q    <= frm_d;
         mode_q   <= mode_d;
         de_s1_q  <= de_s1_d;
         hs_s1_q  <= hs_s1_d;
         vs_s1_q  <= vs_s1_d;
         de_out_q <= de_out_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
      end
   end

   vga_chan_reduce #(.IN_W(IN_W), .OUT_W(OUT_W)) u_red (
      .vga_clk(vga_clk), .reset(reset), .de_s1(de_s1_q), .add(add),
      .pix_in(red_in), .pix_out(red)
   );

   vga_chan_reduce #(.IN_W(IN_W), .OUT_W(OUT_W)) u_green (
      .vga_clk(vga_clk), .reset(reset), .de_s1(de_s1_q), .add(add),
      .pix_in(green_in), .pix_out(green)
   );

   vga_chan_reduce #(.IN_W(IN_W), .OUT_W(OUT_W)) u_blue (
      .vga_clk(vga_clk), .reset(reset), .de_s1(de_s1_q), .add(add),
      .pix_in(blue_in), .pix_out(blue)
   );

   assign de_out = de_out_q;
   assign hsync  = hsync_q;
   assign vsync  = vsync_q;

endmodule
